// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, majority vote helper and
// default link constants common to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned UART_CLK_HZ       = 65_000_000;
  localparam int unsigned UART_BAUD_RATE    = 9600;
  localparam int unsigned UART_SAMP_PER_BIT = 16;
  localparam int unsigned UART_PKT_LEN      = 8;
  localparam int unsigned UART_CLK_PER_SAMP = UART_CLK_HZ / UART_BAUD_RATE / UART_SAMP_PER_BIT;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_byte_rx_baud_sampler.sv
// Oversample timebase for the UART receiver: a clock divider producing one
// tick per oversample and a per-bit sample index that wraps every bit period.
module baud_sampler #(
  parameter int unsigned SAMP_PER_BIT = 16,
  parameter int unsigned CLK_PER_SAMP = 423,
  localparam int unsigned SW = $clog2(SAMP_PER_BIT)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          run_i,
  input  logic          restart_i,
  output logic          tick_o,
  output logic [SW-1:0] sample_idx_o,
  output logic          bit_end_o
);

  localparam int unsigned TW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_SAMP - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_BIT - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] samp_q, samp_d;

  assign tick_o       = run_i && (tick_q == TICK_LAST);
  assign bit_end_o    = tick_o && (samp_q == SAMP_LAST);
  assign sample_idx_o = samp_q;

  // Both counters sit at zero while idle so a new frame starts phase-aligned.
  always_comb begin
    tick_d = tick_q;
    samp_d = samp_q;
    if (!run_i || restart_i) begin
      tick_d = '0;
      samp_d = '0;
    end else if (tick_o) begin
      tick_d = '0;
      samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_q <= '0;
      samp_q <= '0;
    end else begin
      tick_q <= tick_d;
      samp_q <= samp_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// Oversampling UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined) with a valid/ready holding register and framing/parity/overrun flags.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = UART_CLK_HZ,
  parameter int unsigned BAUD_RATE    = UART_BAUD_RATE,
  parameter int unsigned SAMP_PER_BIT = UART_SAMP_PER_BIT,
  parameter int unsigned PKT_LEN      = UART_PKT_LEN,
  parameter int unsigned CLK_PER_SAMP = UART_CLK_PER_SAMP
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rx_in,
  input  logic               ready_in,
  output logic [PKT_LEN-1:0] data_out,
  output logic               valid_out,
  output logic               busy_out,
  output logic               frame_err_out,
  output logic               parity_err_out,
  output logic               overrun_out
);

  localparam int unsigned SW  = $clog2(SAMP_PER_BIT);
  localparam int unsigned BW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned MID = SAMP_PER_BIT / 2;
  localparam logic [BW-1:0] BIT_LAST = BW'(PKT_LEN - 1);

  if (SAMP_PER_BIT < 8 || (SAMP_PER_BIT % 2) != 0) begin : g_bad_spb
    $error("SAMP_PER_BIT must be even and at least 8");
  end
  if (CLK_HZ / BAUD_RATE < SAMP_PER_BIT) begin : g_bad_baud
    $error("Baud rate too high for the requested oversampling");
  end

  rx_state_t state_q, state_d;

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]         mid_q, mid_d;
  logic [PKT_LEN-1:0] shift_q, shift_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PKT_LEN-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic               par_bad_q, par_bad_d;
  logic               par_err_q, par_err_d;
`endif

  logic          tick, bit_end, run, start_det, decide, bit_val;
  logic [SW-1:0] sample_idx;

  assign run       = (state_q != IDLE);
  assign start_det = (state_q == IDLE) && rx_prev_q && !rx_s_q;
  assign decide    = tick && (sample_idx == SW'(MID + 1));
  assign bit_val   = maj3(mid_q[0], mid_q[1], rx_s_q);

  baud_sampler #(
    .SAMP_PER_BIT(SAMP_PER_BIT),
    .CLK_PER_SAMP(CLK_PER_SAMP)
  ) u_sampler (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .run_i       (run),
    .restart_i   (start_det),
    .tick_o      (tick),
    .sample_idx_o(sample_idx),
    .bit_end_o   (bit_end)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stop is decided at mid-bit so the next start edge is never missed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_det) state_d = START;
      START:  if (decide && bit_val) state_d = IDLE;
              else if (bit_end) state_d = DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_end && bit_cnt_q == BIT_LAST) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && bit_cnt_q == BIT_LAST) state_d = STOP;
`endif
      STOP:   if (decide) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mid_d       = mid_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    if (tick && sample_idx == SW'(MID - 1)) mid_d[0] = rx_s_q;
    if (tick && sample_idx == SW'(MID))     mid_d[1] = rx_s_q;
    if (valid_q && ready_in) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      DATA: begin
        if (decide)  shift_d   = {bit_val, shift_q[PKT_LEN-1:1]};
        if (bit_end) bit_cnt_d = bit_cnt_q + BW'(1);
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (decide) par_bad_d = (bit_val != ^shift_q);
`endif
      STOP: begin
        if (decide) begin
          if (!bit_val) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_err_d = 1'b1;
`endif
          end else if (!valid_q || ready_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      mid_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_in;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      mid_q       <= mid_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign busy_out      = run;
  assign frame_err_out = frame_err_q;
  assign overrun_out   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_out = par_err_q;
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed frames plus randomized frames
// compared against an event-level model of the receiver's observable behaviour.
module tb_uart_byte_rx;

  localparam int CPS = 4;
  localparam int SPB = 16;
  localparam int PKT = 8;
  localparam int MID = SPB / 2;
  localparam int BIT = CPS * SPB;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = PKT + PAR + 2;

  localparam int K_DELIVER = 1;
  localparam int K_FRAME   = 2;
  localparam int K_PARITY  = 3;
  localparam int K_OVERRUN = 4;
  localparam int K_CONSUME = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic ready = 1'b0;
  logic [PKT-1:0] data;
  logic valid, busy, frameErr, parityErr, overrun;

  uart_byte_rx #(
    .SAMP_PER_BIT(SPB),
    .PKT_LEN     (PKT),
    .CLK_PER_SAMP(CPS)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .rx_in         (rx),
    .ready_in      (ready),
    .data_out      (data),
    .valid_out     (valid),
    .busy_out      (busy),
    .frame_err_out (frameErr),
    .parity_err_out(parityErr),
    .overrun_out   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails = 0;

  typedef struct {
    int cyc;
    int kind;
    int data;
  } ev_t;

  ev_t evQ[$];
  ev_t expQ[$];

  // Model of the holding register as seen from outside
  bit hv = 1'b0;
  logic [PKT-1:0] hd = '0;

  logic pv = 1'b0;
  logic [PKT-1:0] pd = '0;

  function automatic ev_t mkEv(input int c, input int k, input int d);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.data = d;
    return e;
  endfunction

  // Every externally visible event is logged with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frameErr)  evQ.push_back(mkEv(cyc, K_FRAME, 0));
      if (parityErr) evQ.push_back(mkEv(cyc, K_PARITY, 0));
      if (overrun)   evQ.push_back(mkEv(cyc, K_OVERRUN, 0));
      if (valid && (!pv || data != pd)) evQ.push_back(mkEv(cyc, K_DELIVER, int'(data)));
      if (!valid && pv) evQ.push_back(mkEv(cyc, K_CONSUME, 0));
    end
    pv = valid;
    pd = data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compareEvents(input string tag);
    int n;
    checkOutput({tag, ".count"}, evQ.size(), expQ.size());
    n = (evQ.size() < expQ.size()) ? evQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".kind"}, evQ[i].kind, expQ[i].kind);
      checkOutput({tag, ".cycle"}, evQ[i].cyc, expQ[i].cyc);
      checkOutput({tag, ".data"}, evQ[i].data, expQ[i].data);
    end
    evQ.delete();
    expQ.delete();
  endtask

  task automatic idleCycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame; rdy pulses ready_in in the stop-decision cycle and
  // resetAt >= 0 pulses reset at that clock offset into the frame.
  task automatic applyStimulus(input logic [PKT-1:0] d, input logic parBit, input logic stopBit,
                               input bit rdy, input int resetAt, input string tag);
    logic [NB-1:0] bits;
    int k, e;
    bit good;
    bits[0] = 1'b0;
    for (int i = 0; i < PKT; i++) bits[1 + i] = d[i];
    if (PAR != 0) bits[PKT + 1] = parBit;
    bits[NB - 1] = stopBit;
    k = cyc;
    e = k + 3 + CPS * (SPB * (NB - 1) + MID + 2);
    for (int t = 0; t < NB * BIT; t++) begin
      rx = bits[t / BIT];
      ready = rdy && (cyc == e - 1);
      if (resetAt >= 0 && t == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput({tag, ".rstValid"}, valid, 0);
        checkOutput({tag, ".rstData"}, data, 0);
        checkOutput({tag, ".rstBusy"}, busy, 0);
        checkOutput({tag, ".rstErr"}, {frameErr, parityErr, overrun}, 0);
        hv = 1'b0;
      end else if (resetAt >= 0 && t == resetAt + 1) begin
        rst_n = 1'b1;
      end
      if (resetAt < 0) begin
        if (t == 2) checkOutput({tag, ".busyPre"}, busy, 0);
        if (t == 3) checkOutput({tag, ".busyRise"}, busy, 1);
        if (cyc == e - 1) checkOutput({tag, ".busyStop"}, busy, 1);
        if (cyc == e) checkOutput({tag, ".busyFall"}, busy, 0);
      end
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    ready = 1'b0;
    if (resetAt < 0) begin
      good = stopBit && (PAR == 0 || parBit == ^d);
      if (!stopBit) expQ.push_back(mkEv(e, K_FRAME, 0));
      else if (!good) expQ.push_back(mkEv(e, K_PARITY, 0));
      else if (hv && !rdy) expQ.push_back(mkEv(e, K_OVERRUN, 0));
      if (good && (!hv || rdy)) begin
        expQ.push_back(mkEv(e, K_DELIVER, int'(d)));
        hv = 1'b1;
        hd = d;
      end else if (rdy && hv) begin
        expQ.push_back(mkEv(e, K_CONSUME, 0));
        hv = 1'b0;
      end
    end
    compareEvents(tag);
  endtask

  task automatic drainPulse(input string tag);
    int c;
    ready = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    ready = 1'b0;
    if (hv) begin
      expQ.push_back(mkEv(c + 1, K_CONSUME, 0));
      hv = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    compareEvents(tag);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PKT-1:0] d;
    logic stopBit, parBit;
    bit rdy;
    int k;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.data", data, 0);
    checkOutput("reset.valid", valid, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.frameErr", frameErr, 0);
    checkOutput("reset.parityErr", parityErr, 0);
    checkOutput("reset.overrun", overrun, 0);
    rst_n = 1'b1;
    idleCycles(10);

    applyStimulus(8'hA5, ^8'hA5, 1'b1, 1'b0, -1, "a5");
    idleCycles(20);
    checkOutput("a5.holdValid", valid, 1);
    checkOutput("a5.holdData", data, 8'hA5);
    drainPulse("a5.drain");
    checkOutput("a5.cleared", valid, 0);

    k = cyc;
    for (int t = 0; t < 5 * CPS; t++) begin
      rx = 1'b0;
      if (t == 4) checkOutput("glitch.busy", busy, 1);
      @(posedge clk);
      #1;
    end
    idleCycles(2 * BIT);
    checkOutput("glitch.busyEnd", busy, 0);
    checkOutput("glitch.valid", valid, 0);
    compareEvents("glitch");

    applyStimulus(8'h3C, ^8'h3C, 1'b0, 1'b0, -1, "ferr");
    idleCycles(BIT);
    checkOutput("ferr.valid", valid, 0);
    applyStimulus(8'h11, ^8'h11, 1'b1, 1'b0, -1, "after_ferr");
    checkOutput("after_ferr.data", data, 8'h11);
    drainPulse("after_ferr.drain");

    applyStimulus(8'h3C, ^8'h3C, 1'b1, 1'b0, -1, "b2b1");
    applyStimulus(8'h5A, ^8'h5A, 1'b1, 1'b0, -1, "b2b2");
    checkOutput("b2b.keepData", data, 8'h3C);
    drainPulse("b2b.drain");
    applyStimulus(8'h3C, ^8'h3C, 1'b1, 1'b0, -1, "b2b3");
    applyStimulus(8'h5A, ^8'h5A, 1'b1, 1'b1, -1, "b2b4");
    checkOutput("b2b.newData", data, 8'h5A);
    checkOutput("b2b.stillValid", valid, 1);
    drainPulse("b2b.drain2");

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b0, -1, "perr");
    idleCycles(BIT);
    checkOutput("perr.valid", valid, 0);
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, -1, "pok");
    checkOutput("pok.data", data, 8'h01);
    drainPulse("pok.drain");
`endif

    applyStimulus(8'h77, ^8'h77, 1'b1, 1'b0, -1, "prefill");
    applyStimulus(8'hFF, ^8'hFF, 1'b1, 1'b0, BIT * 5 + BIT / 2, "midreset");
    idleCycles(BIT);
    checkOutput("midreset.valid", valid, 0);
    applyStimulus(8'h42, ^8'h42, 1'b1, 1'b0, -1, "after_reset");
    checkOutput("after_reset.data", data, 8'h42);
    drainPulse("after_reset.drain");

    for (int n = 0; n < 16; n++) begin
      d = PKT'($urandom);
      stopBit = ($urandom_range(0, 4) != 0);
      parBit = (^d) ^ ($urandom_range(0, 3) == 0);
      rdy = $urandom_range(0, 1) != 0;
      if (hv && rdy && d == hd) d = d ^ PKT'(1);
      applyStimulus(d, parBit, stopBit, rdy, -1, "rand");
      if (!stopBit) idleCycles(BIT);
      if ($urandom_range(0, 2) == 0) drainPulse("rand.drain");
      idleCycles($urandom_range(0, 20));
    end
    drainPulse("final.drain");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Oversampling UART byte receiver for the inter-board move link: it takes the raw serial line from the peer board's transmitter and recovers each 8N1 frame (optionally 8E1), sent LSB first. It presents the byte on a valid/ready holding register that the game FSM or move mux drains. It flags framing, parity and overrun errors. It sits between the peer-link input pin and the move path, clocked from the 65 MHz system clock.

## Interface
- CLK_HZ, 65_000_000, system clock frequency (documentation only)
- BAUD_RATE, 9600, line bit rate (documentation only)
- SAMP_PER_BIT, 16, oversamples per bit; must be even and ≥ 8
- PKT_LEN, 8, data bits per frame
- CLK_PER_SAMP, 423, clocks per oversample tick (CLK_HZ/BAUD_RATE/SAMP_PER_BIT)
- clk_in  input  1  system clock; all state is on the rising edge
- rst_n_in  input  1  reset, asynchronous assert, active-low
- rx_in  input  1  raw serial line, asynchronous, idle high
- ready_in  input  1  consumer accepts data_out this cycle
- data_out  output  PKT_LEN  received byte; stable while valid_out=1
- valid_out  output  1  holding register full
- busy_out  output  1  frame reception in progress (state ≠ IDLE)
- frame_err_out  output  1  one-cycle pulse: stop bit sampled 0
- parity_err_out  output  1  one-cycle pulse: parity mismatch (tied 0 without macro)
- overrun_out  output  1  one-cycle pulse: completed byte dropped because holding register full

## Operation
- rx_in passes through a 2-flop synchronizer reset to 1. All logic uses the synchronized value rx_s.
- Tick counter counts 0..CLK_PER_SAMP-1 and emits a 1-cycle tick at wrap. It is held at 0 in IDLE and restarts on start detection.
- Sample counter runs 0..SAMP_PER_BIT-1 per bit on ticks. The bit value is the majority of samples MID-1, MID and MID+1, where MID = SAMP_PER_BIT/2.
- States:
  - IDLE: wait for a 1→0 transition on rx_s (previous registered rx_s = 1). A line held low after reset or error never starts a frame. Go to START.
  - START: at the majority decision, a value of 1 is a false start → IDLE. A value of 0 goes to DATA at the end of the bit.
  - DATA: shift PKT_LEN bits in LSB first, right-shift register. After the last bit, go to PARITY if UART_RX_PARITY_EN is defined, else STOP.
  - PARITY: compare the sampled bit with the even-parity expectation, ^data. Record any mismatch. Go to STOP.
  - STOP: decide at the mid-bit majority; return to IDLE right at the decision (half-bit early) so back-to-back frames are caught.
- Stop decision outcomes:
  - Stop bit 0: pulse frame_err_out; byte discarded.
  - Stop bit 1 with a parity mismatch: pulse parity_err_out; byte discarded.
  - Stop bit 1, no mismatch: byte is delivered.
- Delivery:
  - valid_out=0, or valid_out=1 with ready_in=1 in the same cycle: load data_out and set valid_out=1.
  - valid_out=1 with ready_in=0: keep the old byte and pulse overrun_out.
- Consumption: ready_in=1 while valid_out=1 with no simultaneous delivery clears valid_out next cycle.
- ready_in while valid_out=0 is ignored.
- rst_n_in low at any point, including mid-frame, aborts the frame immediately. It returns to IDLE with all outputs at reset values.

## Timing
- Reset values: data_out 0, valid_out 0, busy_out 0, all error pulses 0, synchronizer 1, counters 0, state IDLE.
- rx_in edge to rx_s: 2 clocks.
- Error pulses and the valid_out rise are registered. Each occurs exactly 1 clock after the tick carrying sample MID+1 of the stop bit.
- Error and overrun pulses are exactly 1 cycle wide. They are never asserted together.
- busy_out rises the clock after start detection. It falls in the same cycle the stop decision is registered.
- Nominal frame-end-to-valid latency at default parameters: about half a bit time (≈3.4k clocks) before the stop-bit end.
- Tolerates ±3 % baud mismatch.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is start + PKT_LEN data + even parity + stop.
  - PARITY state is present.
  - parity_err_out is live.
- UART_RX_PARITY_EN not defined:
  - Frame is 8N1.
  - PARITY state and its logic are absent.
  - parity_err_out is driven constant 0.

## Structure
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Helper function maj3.
  - Default parameter constants, shared with the transmitter.
- One sub-module, baud_sampler. It is the tick counter plus sample counter, with a restart input and tick/sample_idx/bit_end outputs.
- Top of uart_byte_rx holds the synchronizer, FSM, shifter and holding register.

## Test plan
(Bench uses CLK_PER_SAMP=4, SAMP_PER_BIT=16, PKT_LEN=8.)
- Frame 0xA5 with ready_in=0:
  - valid_out=1 and data_out=0xA5 one clock after the stop mid-sample.
  - Holds until ready_in=1 is pulsed, then valid_out=0 the next clock.
- Low glitch of 5 samples on an idle line → START rejects it, busy_out returns 0, no valid_out, no error pulses.
- Frame 0x3C with stop bit 0 → frame_err_out 1-cycle pulse, valid_out stays 0. Line then returns high and frame 0x11 → data_out=0x11.
- Back-to-back frames 0x3C, 0x5A with ready_in=0 → data_out=0x3C retained, overrun_out pulses once. Repeat with ready_in=1 at the delivery cycle → data_out=0x5A, valid_out stays 1.
- With UART_RX_PARITY_EN, frame 0x01 with parity bit 0 → parity_err_out pulse and no valid_out. The same frame with parity bit 1 → data_out=0x01.
- rst_n_in low for 1 clock during data bit 4 of 0xFF → all outputs 0 immediately. Remaining bits are not taken as a frame. The next frame 0x42 is received correctly.
